// File: rtl/nios2_debug_host_shifter.sv
// Host-side virtual-JTAG initiator for the Nios II debug slave: turns one IR/DR
// command into a UIR-CDR-SDR-UDR-RTI tck sequence and returns the captured tdo word.
module nios2_debug_host_shifter #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RTI  = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    localparam int            CW       = $clog2(DR_WIDTH + 1);
    localparam logic [7:0]    DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(DR_WIDTH - 1);

    logic [2:0]          r_state;
    logic [7:0]          r_div;
    logic                r_tck;
    logic                r_tdi;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_uir, r_cdr, r_sdr, r_udr, r_rti;
    logic [DR_WIDTH-1:0] r_tx;
    logic [DR_WIDTH-1:0] r_cap;
    logic [CW-1:0]       r_bit;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_data;
    logic [IR_WIDTH-1:0] r_rsp_ir;

    logic w_cmd_ready;
    logic w_div_end;

    assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_div_end   = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_tck       <= 1'b0;
            r_tdi       <= 1'b0;
            r_ir_in     <= '0;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
            r_rti       <= 1'b0;
            r_tx        <= '0;
            r_cap       <= '0;
            r_bit       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_ir    <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready)
                r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && w_cmd_ready) begin
                        r_state <= S_UIR;
                        r_ir_in <= cmd_ir;
                        r_tx    <= cmd_data;
                        r_cap   <= '0;
                        r_div   <= '0;
                        r_tck   <= 1'b0;
                        r_uir   <= 1'b1;
                    end
                end
                S_UIR, S_CDR, S_SDR, S_UDR, S_RTI: begin
                    r_div <= w_div_end ? '0 : r_div + 8'd1;
                    // r_tck doubles as the phase flag: low->high is the slave's sample edge
                    if (w_div_end && !r_tck) begin
                        r_tck <= 1'b1;
                        if (r_state == S_UIR)
                            r_rsp_ir <= vji_ir_out;
                        if (r_state == S_SDR)
                            r_cap <= {vji_tdo, r_cap[DR_WIDTH-1:1]};
                    end
                    if (w_div_end && r_tck) begin
                        r_tck <= 1'b0;
                        case (r_state)
                            S_UIR: begin
                                r_uir   <= 1'b0;
                                r_cdr   <= 1'b1;
                                r_state <= S_CDR;
                            end
                            S_CDR: begin
                                r_cdr   <= 1'b0;
                                r_sdr   <= 1'b1;
                                r_tdi   <= r_tx[0];
                                r_tx    <= r_tx >> 1;
                                r_bit   <= '0;
                                r_state <= S_SDR;
                            end
                            S_SDR: begin
                                if (r_bit == BIT_LAST) begin
                                    r_sdr   <= 1'b0;
                                    r_udr   <= 1'b1;
                                    r_tdi   <= 1'b0;
                                    r_state <= S_UDR;
                                end else begin
                                    r_tdi <= r_tx[0];
                                    r_tx  <= r_tx >> 1;
                                    r_bit <= r_bit + CW'(1);
                                end
                            end
                            S_UDR: begin
                                r_udr   <= 1'b0;
                                r_rti   <= 1'b1;
                                r_state <= S_RTI;
                            end
                            default: begin
                                r_rti   <= 1'b0;
                                r_state <= S_RESP;
                            end
                        endcase
                    end
                end
                S_RESP: begin
                    r_rsp_data  <= r_cap;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_ir_out = r_rsp_ir;
    assign vji_tck    = r_tck;
    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = r_uir;
    assign vji_cdr    = r_cdr;
    assign vji_sdr    = r_sdr;
    assign vji_udr    = r_udr;
    assign vji_rti    = r_rti;

endmodule

// File: tb/tb_nios2_debug_host_shifter.sv
// Scoreboard bench for nios2_debug_host_shifter: default and TCK_DIV=1 instances,
// loopback slave model, strobe-order monitor, backpressure and mid-SDR reset.
module tb_nios2_debug_host_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [37:0] cmd_data, rsp_data;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
    logic [1:0]  cmd_ir_b, rsp_ir_out_b, vji_ir_in_b, vji_ir_out_b;
    logic [37:0] cmd_data_b, rsp_data_b;
    logic        vji_tck_b, vji_tdi_b, vji_tdo_b;
    logic        vji_uir_b, vji_cdr_b, vji_sdr_b, vji_udr_b, vji_rti_b;

    nios2_debug_host_shifter #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    nios2_debug_host_shifter #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)) u_dut_div1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_ir_out(rsp_ir_out_b),
        .vji_tck(vji_tck_b), .vji_tdi(vji_tdi_b), .vji_tdo(vji_tdo_b),
        .vji_ir_in(vji_ir_in_b), .vji_ir_out(vji_ir_out_b),
        .vji_uir(vji_uir_b), .vji_cdr(vji_cdr_b), .vji_sdr(vji_sdr_b), .vji_udr(vji_udr_b), .vji_rti(vji_rti_b)
    );

    typedef struct {
        logic [37:0] d;
        logic [1:0]  ir;
        int          lat;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Loopback slave: tdo = reg[0], shifts tdi in on each tck rise during SDR.
    logic [37:0] model;
    logic        model_load, model_tck_d, loop_en, tdo_const;
    assign vji_tdo = loop_en ? model[0] : tdo_const;

    always @(posedge clk) begin
        if (model_load)
            model <= 38'h00_1234_5678;
        else if (vji_tck && !model_tck_d && vji_sdr)
            model <= {vji_tdi, model[37:1]};
        model_tck_d <= vji_tck;
    end

    function automatic logic [4:0] exp_code(input int p);
        if (p == 0)  return 5'b10000;
        if (p == 1)  return 5'b01000;
        if (p <= 39) return 5'b00100;
        if (p == 40) return 5'b00010;
        return 5'b00001;
    endfunction

    int   mon_pos = 0;
    int   sdr_cnt = 0;
    int   udr_cnt = 0;
    logic mon_prev_tck = 1'b0;
    logic mon_prev_udr = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_pos      = 0;
            mon_prev_tck = 1'b0;
            mon_prev_udr = 1'b0;
        end else begin
            if (vji_tck && !mon_prev_tck) begin
                if (mon_pos == 0) sdr_cnt = 0;
                check_eq("strobe_order", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}),
                         64'(exp_code(mon_pos)));
                if (vji_sdr) sdr_cnt++;
                if (mon_pos == 41) begin
                    check_eq("sdr_rises", 64'(sdr_cnt), 64'd38);
                    mon_pos = 0;
                end else begin
                    mon_pos++;
                end
            end
            if (vji_udr && !mon_prev_udr) udr_cnt++;
            mon_prev_tck = vji_tck;
            mon_prev_udr = vji_udr;
        end
    end

    function automatic logic [37:0] rnd38();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[37:0];
    endfunction

    task automatic issue(input logic [1:0] ir, input logic [37:0] data,
                         input logic [37:0] exp_d, input logic [1:0] exp_ir, input int lat);
        int n;
        exp_t e;
        e.d = exp_d; e.ir = exp_ir; e.lat = lat;
        q.push_back(e);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        check_eq("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        @(negedge clk);
        t_acc     = cyc;
        cmd_valid = 1'b0;
        cmd_ir    = ~ir;
        cmd_data  = rnd38();
        check_eq("ir_in_after_accept", 64'(vji_ir_in), 64'(ir));
    endtask

    task automatic collect(input int hold, input bit probe);
        int   n;
        exp_t e;
        logic [1:0] ir_before;
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        e = q.pop_front();
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
            return;
        end
        check_eq("latency", 64'(cyc - t_acc), 64'(e.lat));
        check_eq("rsp_data", 64'(rsp_data), 64'(e.d));
        check_eq("rsp_ir_out", 64'(rsp_ir_out), 64'(e.ir));
        ir_before = vji_ir_in;
        for (int i = 0; i < hold; i++) begin
            if (probe && i == 0) begin
                cmd_valid = 1'b1;
                cmd_ir    = 2'b11;
                cmd_data  = rnd38();
            end
            @(negedge clk);
            check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("bp_rsp_data", 64'(rsp_data), 64'(e.d));
            check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check_eq("bp_ir_in_held", 64'(vji_ir_in), 64'(ir_before));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
        check_eq("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
        check_eq("idle_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tck}), 64'd0);
        if (probe) begin
            e.d = 38'h3F_FFFF_FFFF; e.ir = 2'b10; e.lat = 337;
            q.push_back(e);
            @(negedge clk);
            t_acc     = cyc;
            cmd_valid = 1'b0;
            check_eq("probe_accepted", 64'(vji_ir_in), 64'd3);
        end
    endtask

    initial begin
        int   n;
        int   u0;
        exp_t e;

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
        vji_ir_out = 2'b10; tdo_const = 1'b1; loop_en = 1'b0; model_load = 1'b0;
        cmd_valid_b = 1'b0; cmd_ir_b = 2'b01; cmd_data_b = '0; rsp_ready_b = 1'b1;
        vji_ir_out_b = 2'b01; vji_tdo_b = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_rsp_ir", 64'(rsp_ir_out), 64'd0);
        check_eq("rst_vji", 64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        reset_n = 1'b1;

        // tdo tied high
        issue(2'b01, 38'h15_A5A5_A5A5, 38'h3F_FFFF_FFFF, 2'b10, 337);
        collect(0, 1'b0);

        // loopback slave
        model_load = 1'b1;
        @(negedge clk);
        model_load = 1'b0;
        loop_en = 1'b1;
        issue(2'b10, 38'h2A_AAAA_AAAA, 38'h00_1234_5678, 2'b10, 337);
        collect(0, 1'b0);
        check_eq("loopback_model", 64'(model), 64'h2A_AAAA_AAAA);
        loop_en = 1'b0;

        // backpressure with a competing command
        issue(2'b01, rnd38(), 38'h3F_FFFF_FFFF, 2'b10, 337);
        collect(50, 1'b1);
        collect(0, 1'b0);

        // reset during SDR bit 17
        issue(2'b11, rnd38(), 38'h3F_FFFF_FFFF, 2'b10, 337);
        n = 0;
        while (!(vji_sdr && sdr_cnt == 17) && n < 1000) begin @(negedge clk); n++; end
        check_eq("reached_sdr17", 64'(vji_sdr && sdr_cnt == 17), 64'd1);
        u0 = udr_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("mid_rst_rsp", 64'({rsp_valid, rsp_data, rsp_ir_out}), 64'd0);
        check_eq("mid_rst_vji", 64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        e = q.pop_front();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("no_udr_after_reset", 64'(udr_cnt), 64'(u0));
        issue(2'b01, 38'h15_A5A5_A5A5, 38'h3F_FFFF_FFFF, 2'b10, 337);
        collect(0, 1'b0);

        // TCK_DIV=1, tdo tied low
        e.d = '0; e.ir = 2'b01; e.lat = 85;
        q.push_back(e);
        @(negedge clk);
        check_eq("div1_cmd_ready", 64'(cmd_ready_b), 64'd1);
        cmd_valid_b = 1'b1;
        cmd_data_b  = rnd38();
        @(negedge clk);
        t_acc = cyc;
        cmd_valid_b = 1'b0;
        n = 0;
        while (!rsp_valid_b && n < 500) begin @(negedge clk); n++; end
        e = q.pop_front();
        check_eq("div1_rsp_valid", 64'(rsp_valid_b), 64'd1);
        check_eq("div1_latency", 64'(cyc - t_acc), 64'(e.lat));
        check_eq("div1_rsp_data", 64'(rsp_data_b), 64'(e.d));
        check_eq("div1_rsp_ir", 64'(rsp_ir_out_b), 64'(e.ir));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
